// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame sequencer.
package led_pkg;

  localparam int LED_CHAN_W = 8;
  localparam int LED_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_LATCH
  } led_state_e;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp to at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Valid/ready word stream from the frame sequencer to the bit serializer.
interface led_frame_sequencer_if;
  import led_pkg::*;

  logic [LED_WORD_W-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/led_scale.sv
// Global brightness scaling: each channel becomes bits [15:8] of c*(brightness+1).
module led_scale
  import led_pkg::*;
(
  input  logic [3*LED_CHAN_W-1:0] pix_i,
  input  logic [LED_CHAN_W-1:0]   bright_i,
  output logic [3*LED_CHAN_W-1:0] pix_o
);

  // brightness+1 needs nine bits so that 255 maps to a gain of exactly 256.
  logic [LED_CHAN_W:0] gain;
  assign gain = {1'b0, bright_i} + {{LED_CHAN_W{1'b0}}, 1'b1};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    assign pix_o[c*LED_CHAN_W +: LED_CHAN_W] = LED_CHAN_W'(
      ({{LED_CHAN_W{1'b0}}, pix_i[c*LED_CHAN_W +: LED_CHAN_W]} *
       {{(LED_CHAN_W-1){1'b0}}, gain}) >> LED_CHAN_W);
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame-level controller: fetches one colour word per LED from the pixel RAM,
// streams it to the serializer, enforces the strip latch gap and re-triggers on
// start or on the auto-refresh timer.
// Optional feature: define LED_BRIGHTNESS_EN to scale colours by `brightness`.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = 64,
  parameter int LATCH_CYCLES   = 6000,
  parameter int REFRESH_CYCLES = 1666666
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [LED_CHAN_W-1:0] brightness,
  output logic                  rd_en,
  output logic [8:0]            rd_addr,
  input  logic [LED_WORD_W-1:0] rd_data,
  led_frame_sequencer_if.master m,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (clog2(NUM_LEDS) < 1) ? 1 : clog2(NUM_LEDS);
  localparam int LAT_W = (clog2(LATCH_CYCLES) < 1) ? 1 : clog2(LATCH_CYCLES);
  localparam int TMR_W = (clog2(REFRESH_CYCLES) < 1) ? 1 : clog2(REFRESH_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_END    = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_PRE    = LAT_W'(LATCH_CYCLES - 2);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);

  led_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [LAT_W-1:0]       lat_q;
  logic [TMR_W-1:0]       tmr_q;
  logic                   pend_q, pend_d;
  logic                   pend_tmr_q, pend_tmr_d;
  logic                   rd_en_q;
  logic [3*LED_CHAN_W-1:0] tdata_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic                   done_q;

  logic                   tmr_expired;
  logic                   trigger;
  logic                   pend_live;
  logic                   latch_end;
  logic                   frame_start;
  logic [3*LED_CHAN_W-1:0] pix_scaled;

`ifdef LED_BRIGHTNESS_EN
  led_scale u_scale (
    .pix_i    (rd_data[3*LED_CHAN_W-1:0]),
    .bright_i (brightness),
    .pix_o    (pix_scaled)
  );
  logic unused_bits;
  assign unused_bits = ^rd_data[LED_WORD_W-1:3*LED_CHAN_W];
`else
  assign pix_scaled = rd_data[3*LED_CHAN_W-1:0];
  logic unused_bits;
  assign unused_bits = ^{brightness, rd_data[LED_WORD_W-1:3*LED_CHAN_W]};
`endif

  // A start and a timer expiry in the same cycle merge into one trigger.
  assign tmr_expired = (tmr_q == '0);
  assign trigger     = start | (tmr_expired & auto_en);
  // A timer-generated pending request is withdrawn as soon as auto_en drops.
  assign pend_live   = pend_q & ~(pend_tmr_q & ~auto_en);
  assign latch_end   = (state_q == S_LATCH) && (lat_q == LAT_END);
  assign frame_start = (trigger | pend_live) & ((state_q == S_IDLE) | latch_end);

  // Next state of the one-deep pending-trigger flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pend_d     = pend_live;
    pend_tmr_d = pend_live & pend_tmr_q;
    if (frame_start) begin
      pend_d     = 1'b0;
      pend_tmr_d = 1'b0;
    end else if ((state_q != S_IDLE) && trigger) begin
      pend_d     = 1'b1;
      // A start promotes a timer-made request so auto_en cannot cancel it.
      pend_tmr_d = pend_live ? (pend_tmr_q & ~start) : ~start;
    end
  end

  // Pending flag and free-running refresh timer, reloaded at every frame start.
  // NOTE: asynchronous active-low reset; the reset branch must only load constants.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q     <= 1'b0;
      pend_tmr_q <= 1'b0;
      tmr_q      <= TMR_RELOAD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      pend_q     <= pend_d;
      pend_tmr_q <= pend_tmr_d;
      tmr_q      <= (frame_start || tmr_expired) ? TMR_RELOAD : tmr_q - TMR_W'(1);
    end
  end

  // Frame FSM with registered RAM strobe, stream outputs and done pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      rd_en_q  <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q <= S_FETCH;
            idx_q   <= '0;
            rd_en_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          state_q  <= S_SEND;
          tdata_q  <= pix_scaled;
          tvalid_q <= 1'b1;
          tlast_q  <= (idx_q == LAST_IDX);
        end
        S_SEND: begin
          if (m.m_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_LATCH;
              lat_q   <= '0;
              done_q  <= (LATCH_CYCLES == 1);
            end else begin
              state_q <= S_FETCH;
              idx_q   <= idx_q + IDX_W'(1);
              rd_en_q <= 1'b1;
            end
          end
        end
        S_LATCH: begin
          if (lat_q == LAT_END) begin
            if (frame_start) begin
              state_q <= S_FETCH;
              idx_q   <= '0;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            lat_q  <= lat_q + LAT_W'(1);
            // Raised one cycle early so the registered pulse lines up with the
            // last latch-gap cycle.
            done_q <= (LATCH_CYCLES >= 2) && (lat_q == LAT_PRE);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = 9'(idx_q);
  assign m.m_tdata  = {{(LED_WORD_W-3*LED_CHAN_W){1'b0}}, tdata_q};
  assign m.m_tvalid = tvalid_q;
  assign m.m_tlast  = tlast_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer: a synchronous pixel RAM model,
// a stream monitor holding the expected frame order/timing, and directed plus
// randomized scenarios.
module tb_led_frame_sequencer;
  import led_pkg::*;

  localparam int NL = 4;
  localparam int LC = 30;
  localparam int RC = 200;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic [7:0]  brightness = 8'hFF;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        busy;
  logic        frame_done;

  led_frame_sequencer_if sif ();

  led_frame_sequencer #(
    .NUM_LEDS       (NL),
    .LATCH_CYCLES   (LC),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .auto_en    (auto_en),
    .brightness (brightness),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m          (sif.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pixel RAM: data valid one cycle after rd_en.
  logic [31:0] mem [0:511];
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected stream word for a raw RAM word, from the colour/brightness rules.
  function automatic logic [31:0] model_word(input logic [31:0] raw);
`ifdef LED_BRIGHTNESS_EN
    int r, g, b;
    r = (int'(raw[23:16]) * (int'(brightness) + 1)) / 256;
    g = (int'(raw[15:8])  * (int'(brightness) + 1)) / 256;
    b = (int'(raw[7:0])   * (int'(brightness) + 1)) / 256;
    return {8'h00, 8'(r), 8'(g), 8'(b)};
`else
    return {8'h00, raw[23:0]};
`endif
  endfunction

  // Serializer ready: 0 = always ready, 1 = random stalls, 2 = held low.
  int ready_mode = 0;
  initial begin
    sif.m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       sif.m_tready = 1'b1;
        1:       sif.m_tready = ($urandom_range(0, 3) != 0);
        default: sif.m_tready = 1'b0;
      endcase
    end
  end

  // Stream monitor / reference: expected address order, data, last flag and timing.
  int          exp_idx = 0;
  int          rd_cyc = 0, hs_cyc = 0, final_hs_cyc = 0;
  bit          have_final = 1'b0;
  bit          prev_hold = 1'b0;
  int          hs_count = 0, rd_count = 0, done_count = 0, last_count = 0;
  int          starts[$];
  logic [31:0] word_log[$];

  always @(negedge clock) begin
    if (!resetn) begin
      exp_idx    = 0;
      prev_hold  = 1'b0;
      have_final = 1'b0;
    end else begin
      if (rd_en) begin
        rd_count++;
        check("rd_addr", 32'(rd_addr), 32'(exp_idx));
        if (exp_idx == 0) begin
          starts.push_back(cyc);
          if (have_final) check("latch_gap_min", 32'((cyc - final_hs_cyc) > LC), 32'd1);
        end else begin
          check("rd_after_hs", cyc, hs_cyc + 1);
        end
        rd_cyc = cyc;
      end
      if (sif.m_tvalid) begin
        if (!prev_hold) check("valid_latency", cyc, rd_cyc + 2);
        check("tdata", sif.m_tdata, model_word(mem[exp_idx]));
        check("tlast", 32'(sif.m_tlast), 32'(exp_idx == NL - 1));
        if (sif.m_tready) begin
          hs_count++;
          hs_cyc = cyc;
          word_log.push_back(sif.m_tdata);
          if (sif.m_tlast) last_count++;
          if (exp_idx == NL - 1) begin
            final_hs_cyc = cyc;
            have_final   = 1'b1;
            exp_idx      = 0;
          end else begin
            exp_idx++;
          end
        end
      end
      prev_hold = sif.m_tvalid && !sif.m_tready;
      if (frame_done) begin
        done_count++;
        check("frame_done_time", cyc, final_hs_cyc + LC);
      end
    end
  end

  int start_cyc = 0;

  task automatic pulse_start();
    @(posedge clock);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < budget);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(hs_count >= target), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (starts.size() < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(starts.size()), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  32'(rd_en),          32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr),       32'd0);
    check({tag, "_tdata"},  sif.m_tdata,         32'd0);
    check({tag, "_tvalid"}, 32'(sif.m_tvalid),   32'd0);
    check({tag, "_tlast"},  32'(sif.m_tlast),    32'd0);
    check({tag, "_busy"},   32'(busy),           32'd0);
    check({tag, "_done"},   32'(frame_done),     32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int          hs0, dn0, rd0, lst0, a_final;
  logic [31:0] held;
  logic [7:0]  bsel [3];
  logic [31:0] bexp [3];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Reset values.
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_after_reset", 32'(busy), 32'd0);

    // Directed frame: incrementing colours, always ready.
    for (int i = 0; i < NL; i++) mem[i] = 32'h00A1B2C3 + 32'(i) * 32'h00010101;
    brightness = 8'hFF;
    starts.delete();
    hs0 = hs_count; dn0 = done_count; lst0 = last_count;
    pulse_start();
    wait_idle("frame1_idle", 500);
    check("frame1_hs", 32'(hs_count - hs0), NL);
    check("frame1_done", 32'(done_count - dn0), 32'd1);
    check("frame1_last", 32'(last_count - lst0), 32'd1);
    check("frame1_starts", 32'(starts.size()), 32'd1);
    check("start_to_rd_en", starts[0], start_cyc + 1);

    // Brightness corner cases on one pixel (top byte must be discarded).
    bsel[0] = 8'h00; bsel[1] = 8'h7F; bsel[2] = 8'hFF;
`ifdef LED_BRIGHTNESS_EN
    bexp[0] = 32'h00000000; bexp[1] = 32'h007F4000; bexp[2] = 32'h00FF8001;
`else
    bexp[0] = 32'h00FF8001; bexp[1] = 32'h00FF8001; bexp[2] = 32'h00FF8001;
`endif
    for (int k = 0; k < 3; k++) begin
      mem[0]     = 32'hABFF8001;
      brightness = bsel[k];
      word_log.delete();
      pulse_start();
      wait_idle("bright_idle", 500);
      check("bright_word0", word_log[0], bexp[k]);
    end

    // Randomized frames with random stalls, pixels and brightness.
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NL; i++) mem[i] = $urandom;
      brightness = 8'($urandom_range(0, 255));
      hs0 = hs_count; dn0 = done_count;
      pulse_start();
      wait_idle("rand_idle", 2000);
      check("rand_hs", 32'(hs_count - hs0), NL);
      check("rand_done", 32'(done_count - dn0), 32'd1);
    end

    // Serializer stalled for 50 cycles mid-frame.
    ready_mode = 0;
    pulse_start();
    wait_hs("stall_reach", hs_count + 2, 100);
    ready_mode = 2;
    repeat (5) @(negedge clock);
    hs0 = hs_count; rd0 = rd_count; held = sif.m_tdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(sif.m_tvalid), 32'd1);
      check("stall_data", sif.m_tdata, held);
    end
    check("stall_no_hs", 32'(hs_count), 32'(hs0));
    check("stall_no_fetch", 32'(rd_count), 32'(rd0));
    ready_mode = 0;
    wait_idle("stall_idle", 500);

    // Two starts during a frame produce exactly one extra frame after the gap.
    starts.delete();
    dn0 = done_count;
    pulse_start();
    wait_hs("dbl_reach", hs_count + 1, 100);
    pulse_start();
    repeat (3) @(negedge clock);
    pulse_start();
    wait_starts("dbl_second", 2, 500);
    check("dbl_restart_time", starts[1], final_hs_cyc + LC + 1);
    wait_idle("dbl_idle", 500);
    repeat (3 * LC) @(negedge clock);
    check("dbl_frames", 32'(starts.size()), 32'd2);
    check("dbl_done", 32'(done_count - dn0), 32'd2);

    // Auto-refresh: frame starts spaced exactly one refresh period.
    starts.delete();
    auto_en = 1'b1;
    wait_starts("auto_starts", 4, 5 * RC);
    for (int i = 0; i < 3; i++) check("auto_period", starts[i+1] - starts[i], RC);
    auto_en = 1'b0;
    wait_idle("auto_idle", 500);

    // Refresh period shorter than a (stalled) frame: back-to-back frames.
    starts.delete();
    @(posedge clock);
    #1;
    auto_en = 1'b1;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_hs("short_reach", hs_count + 1, 100);
    ready_mode = 2;
    repeat (250) @(negedge clock);
    ready_mode = 0;
    wait_starts("short_second", 2, 500);
    a_final = final_hs_cyc;
    check("short_restart_time", starts[1], a_final + LC + 1);
    // Stall frame B past a timer expiry, then withdraw auto_en before it ends.
    wait_hs("short_reach_b", hs_count + 1, 100);
    ready_mode = 2;
    repeat (250) @(negedge clock);
    auto_en = 1'b0;
    repeat (5) @(negedge clock);
    ready_mode = 0;
    wait_idle("short_idle", 500);
    repeat (300) @(negedge clock);
    check("auto_clear_drops", 32'(starts.size()), 32'd2);
    check("auto_clear_idle", 32'(busy), 32'd0);

    // Reset asserted while a word is being offered.
    ready_mode = 2;
    pulse_start();
    begin
      int n;
      n = 0;
      while (!sif.m_tvalid && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("rst_reach_send", 32'(sif.m_tvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_async_tvalid", 32'(sif.m_tvalid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    resetn     = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_reset_outputs("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Frame-level controller for the serial LED driver. Reads one 24-bit colour word per LED from a synchronous pixel RAM and presents each word over a valid/ready stream to the bit-serializer, asserting last on the final LED. After the frame it enforces the strip latch gap, then repeats on request or on an auto-refresh timer. It sits between the software-written pixel buffer and the serializer FSM.

## Interface
- NUM_LEDS, 64: LEDs per frame, 1..512.
- LATCH_CYCLES, 6000: idle clocks after the last handshake before a new frame may start (60 us at 100 MHz).
- REFRESH_CYCLES, 1666666: auto-refresh period in clocks, measured from frame start to next frame start.
- clock  in  1  system clock, 100 MHz.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request.
- auto_en  in  1  enables periodic auto-refresh.
- brightness  in  8  global brightness; used only when LED_BRIGHTNESS_EN is defined.
- rd_en  out  1  pixel RAM read strobe.
- rd_addr  out  9  pixel RAM address.
- rd_data  in  32  RAM data, valid one cycle after rd_en. Bits [23:0] are colour; bits [31:24] are ignored.
- m_tdata  out  32  word to serializer.
- m_tvalid  out  1  word valid.
- m_tready  in  1  serializer ready.
- m_tlast  out  1  high with the word for LED NUM_LEDS-1.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the latch gap completes.

## Operation
- States:
  - IDLE: wait for a trigger.
  - FETCH: assert rd_en with rd_addr = index.
  - WAIT: RAM latency; capture rd_data, apply scaling.
  - SEND: hold m_tvalid.
  - LATCH: count the latch gap.
- Triggers are a start pulse or a refresh-timer expiry with auto_en=1. Either moves IDLE to FETCH with index=0.
- FETCH always goes to WAIT. WAIT always goes to SEND.
- SEND: m_tvalid=1. m_tdata and m_tlast are held stable until a cycle with m_tvalid and m_tready both high.
  - On handshake with index < NUM_LEDS-1: increment index, go to FETCH.
  - On handshake with index = NUM_LEDS-1: go to LATCH with the gap counter at 0.
- LATCH: counter increments every cycle. When it reaches LATCH_CYCLES-1, pulse frame_done and go to IDLE.
  - If a trigger is pending at that point, go directly to FETCH with index=0 instead. frame_done still pulses.
- Pending trigger:
  - A start, or a timer expiry, while busy sets a one-deep pending flag.
  - Further triggers while the flag is set are dropped.
  - The flag clears when its frame begins.
- Refresh timer:
  - A free-running down-counter, reloaded with REFRESH_CYCLES-1 at each frame start.
  - Expiry generates a trigger only if auto_en=1.
  - Clearing auto_en clears any timer-generated pending flag. It does not abort a frame in flight.
- A start and a timer expiry in the same cycle count as one trigger.
- Indices wrap only by returning to 0 at frame start; rd_addr never exceeds NUM_LEDS-1.
- m_tdata[31:24] is always 0.

## Timing
- Reset values: rd_en=0, rd_addr=0, m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, frame_done=0, state IDLE, pending flag 0, refresh counter REFRESH_CYCLES-1.
- Reset mid-frame aborts the frame immediately. m_tvalid drops asynchronously; no partial-frame recovery.
- Latency:
  - start sampled at cycle N gives rd_en at N+1 and m_tvalid at N+3.
  - A handshake at cycle M gives the next m_tvalid at M+3.
- m_tvalid never depends combinationally on m_tready.
- Minimum idle time between the last handshake and the next frame's first rd_en is LATCH_CYCLES cycles.

## Configuration
- LED_BRIGHTNESS_EN defined:
  - Each 8-bit channel c of rd_data[23:0] becomes bits [15:8] of c*(brightness+1), a 16-bit product.
  - brightness=255 gives identity; brightness=0 gives all zeros.
  - Scaling is registered in WAIT; latency is unchanged.
- LED_BRIGHTNESS_EN undefined: m_tdata[23:0]=rd_data[23:0], and the brightness input is unused.

## Structure
- Package led_pkg holds:
  - the state enum;
  - LED_CHAN_W=8 and LED_WORD_W=32;
  - the address-width function clog2(NUM_LEDS).
- One sub-module, led_scale: three combinational 8x9 multipliers, instantiated only under LED_BRIGHTNESS_EN.

## Test plan
- NUM_LEDS=4, RAM words 0x00A1B2C3.., m_tready always 1, one start pulse -> four handshakes, m_tlast only on the 4th, frame_done exactly LATCH_CYCLES cycles after the 4th handshake.
- m_tready low for 50 cycles mid-frame -> m_tvalid and m_tdata stay stable throughout, no address advance.
- start pulsed twice during a frame -> exactly one extra frame, starting right after the latch gap.
- auto_en=1, REFRESH_CYCLES=20000 -> frame starts spaced exactly 20000 cycles apart. With REFRESH_CYCLES less than the frame length -> back-to-back frames separated by LATCH_CYCLES.
- LED_BRIGHTNESS_EN, brightness=0x7F, pixel 0x00FF8001 -> m_tdata=0x007F4000. brightness=0xFF -> unchanged.
- resetn low during SEND -> m_tvalid=0 immediately. After release, outputs are at reset values and the block waits in IDLE.
